// File: rtl/aes_pkg.sv
// Shared AES byte-cipher helpers for the cipher and decipher ends of the link.
// Contents: forward and inverse AES S-box tables, and the helpers sbox(),
// inv_sbox(), rotl8() and next_key(). The cipher also imports next_key(), so
// both ends chain their keys the same way.
package aes_pkg;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b,
      8'hfe, 8'hd7, 8'hab, 8'h76, 8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0, 8'hb7, 8'hfd, 8'h93, 8'h26,
      8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2,
      8'heb, 8'h27, 8'hb2, 8'h75, 8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84, 8'h53, 8'hd1, 8'h00, 8'hed,
      8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f,
      8'h50, 8'h3c, 8'h9f, 8'ha8, 8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2, 8'hcd, 8'h0c, 8'h13, 8'hec,
      8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14,
      8'hde, 8'h5e, 8'h0b, 8'hdb, 8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79, 8'he7, 8'hc8, 8'h37, 8'h6d,
      8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f,
      8'h4b, 8'hbd, 8'h8b, 8'h8a, 8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e, 8'he1, 8'hf8, 8'h98, 8'h11,
      8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f,
      8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e,
      8'h81, 8'hf3, 8'hd7, 8'hfb, 8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
      8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb, 8'h54, 8'h7b, 8'h94, 8'h32,
      8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49,
      8'h6d, 8'h8b, 8'hd1, 8'h25, 8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
      8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92, 8'h6c, 8'h70, 8'h48, 8'h50,
      8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05,
      8'hb8, 8'hb3, 8'h45, 8'h06, 8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
      8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b, 8'h3a, 8'h91, 8'h11, 8'h41,
      8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8,
      8'h1c, 8'h75, 8'hdf, 8'h6e, 8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
      8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b, 8'hfc, 8'h56, 8'h3e, 8'h4b,
      8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59,
      8'h27, 8'h80, 8'hec, 8'h5f, 8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
      8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef, 8'ha0, 8'he0, 8'h3b, 8'h4d,
      8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63,
      8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[b];
   endfunction

   // Left-rotate by rot mod 8; rot=0 leaves the byte unchanged.
   function automatic logic [7:0] rotl8(input logic [7:0] k, input int unsigned rot);
      int unsigned r;
      r = rot % 8;
      return (k << r) | (k >> ((8 - r) % 8));
   endfunction

   // Key chain step: K_{i+1} = rotl(K_i, rot) ^ C_i ^ idx[7:0].
   function automatic logic [7:0] next_key(input logic [7:0]  k,
                                           input logic [7:0]  c,
                                           input logic [7:0]  idx,
                                           input int unsigned rot = 1);
      return rotl8(k, rot) ^ c ^ idx;
   endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box lookup.
// Ports:
//   data_i  8-bit substituted byte
//   data_o  8-bit inverse-substituted byte
module aes_inv_sbox
   import aes_pkg::*;
(
   input  logic [7:0] data_i,
   output logic [7:0] data_o
);

   always_comb begin
      data_o = inv_sbox(data_i);
   end

endmodule

// File: rtl/aes_decipher.sv
// Byte-serial decipher: P_i = INV_SBOX(C_i) ^ K_i, with the key chained as
// K_{i+1} = rotl(K_i, KEY_ROT) ^ C_i ^ idx[7:0]. One-cycle registered latency.
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   new_message  start of message; loads key and clears idx
//   key          message key, sampled only with new_message
//   valid_in     data_in holds a ciphertext byte
//   data_in      ciphertext byte
//   data_out     registered plaintext byte
//   valid_out    registered strobe, one cycle per accepted byte
//   no_key_err   sticky "byte before any key" flag (only with AES_DECIPHER_ERR_EN)
// Optional feature macro: AES_DECIPHER_ERR_EN.
module aes_decipher
   import aes_pkg::*;
#(
   parameter int unsigned KEY_ROT = 1,
   parameter int unsigned CNT_W   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       new_message,
   input  logic [7:0] key,
   input  logic       valid_in,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       valid_out
`ifdef AES_DECIPHER_ERR_EN
   ,
   output logic       no_key_err
`endif
);

   logic [7:0]       k_q, k_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [7:0]       data_out_q, data_out_d;
   logic             valid_out_q, valid_out_d;

   // Key and index effective for this cycle: a same-cycle new_message makes
   // the incoming byte the first byte of the new message.
   logic [7:0]       k_cur;
   logic [CNT_W-1:0] idx_cur;
   logic [7:0]       inv_byte;

   aes_inv_sbox u_inv_sbox (
      .data_i (data_in),
      .data_o (inv_byte)
   );

   always_comb begin
      k_cur       = new_message ? key : k_q;
      idx_cur     = new_message ? '0 : idx_q;
      k_d         = k_cur;
      idx_d       = idx_cur;
      data_out_d  = data_out_q;
      valid_out_d = 1'b0;
      if (valid_in) begin
         data_out_d  = inv_byte ^ k_cur;
         valid_out_d = 1'b1;
         k_d         = next_key(k_cur, data_in, 8'(idx_cur), KEY_ROT);
         idx_d       = idx_cur + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         k_q         <= 8'h00;
         idx_q       <= '0;
         data_out_q  <= 8'h00;
         valid_out_q <= 1'b0;
      end else begin
         k_q         <= k_d;
         idx_q       <= idx_d;
         data_out_q  <= data_out_d;
         valid_out_q <= valid_out_d;
      end
   end

   assign data_out  = data_out_q;
   assign valid_out = valid_out_q;

`ifdef AES_DECIPHER_ERR_EN
   logic key_seen_q, key_seen_d;
   logic no_key_err_q, no_key_err_d;

   always_comb begin
      key_seen_d   = key_seen_q;
      no_key_err_d = no_key_err_q;
      if (new_message) begin
         key_seen_d   = 1'b1;
         no_key_err_d = 1'b0;
      end else if (valid_in && !key_seen_q) begin
         no_key_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_seen_q   <= 1'b0;
         no_key_err_q <= 1'b0;
      end else begin
         key_seen_q   <= key_seen_d;
         no_key_err_q <= no_key_err_d;
      end
   end

   assign no_key_err = no_key_err_q;
`endif

endmodule

// File: tb/tb_aes_decipher.sv
// Self-checking bench for aes_decipher. The reference S-box is derived from
// GF(2^8) arithmetic; ciphertext comes from a behavioural model of the cipher.
module tb_aes_decipher;

   logic       clk = 1'b0;
   logic       reset;
   logic       new_message;
   logic [7:0] key;
   logic       valid_in;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       valid_out;
`ifdef AES_DECIPHER_ERR_EN
   logic       no_key_err;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] ref_sbox [256];
   logic [7:0] ref_inv  [256];

   // Cipher model state
   logic [7:0] m_k;
   logic [7:0] m_idx;

   aes_decipher dut (
      .clk         (clk),
      .reset       (reset),
      .new_message (new_message),
      .key         (key),
      .valid_in    (valid_in),
      .data_in     (data_in),
      .data_out    (data_out),
      .valid_out   (valid_out)
`ifdef AES_DECIPHER_ERR_EN
      ,
      .no_key_err  (no_key_err)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      logic       hi;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = a << 1;
         if (hi) a = a ^ 8'h1b;
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = b;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   task automatic build_tables();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
         ref_sbox[x] = s;
         ref_inv[s]  = 8'(x);
      end
   endtask

   // Behavioural cipher (KEY_ROT=1): encrypt p and advance the model key chain.
   function automatic logic [7:0] enc(input logic [7:0] p);
      logic [7:0] c;
      c     = ref_sbox[p ^ m_k];
      m_k   = {m_k[6:0], m_k[7]} ^ c ^ m_idx;
      m_idx = m_idx + 8'd1;
      return c;
   endfunction

   task automatic drive(input logic nm, input logic [7:0] k, input logic v,
                        input logic [7:0] c);
      new_message = nm; key = k; valid_in = v; data_in = c;
      @(posedge clk); #1;
      new_message = 1'b0; valid_in = 1'b0;
   endtask

   task automatic do_reset();
      new_message = 1'b0; key = 8'h00; valid_in = 1'b0; data_in = 8'h00;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (data_out !== 8'h00) $display("FAIL reset_data_out got %h want 00", data_out);
      else n_pass++;
      n_checks++;
      if (valid_out !== 1'b0) $display("FAIL reset_valid_out got %b want 0", valid_out);
      else n_pass++;
   endtask

   task automatic test_basic();
      do_reset();
      drive(1'b1, 8'h00, 1'b0, 8'h00);
      n_checks++;
      if (valid_out !== 1'b0) $display("FAIL basic_nm_valid got %b want 0", valid_out);
      else n_pass++;
      drive(1'b0, 8'h00, 1'b1, 8'h63);
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== 8'h00)
         $display("FAIL basic_b0 got %b/%h want 1/00", valid_out, data_out);
      else n_pass++;
      drive(1'b0, 8'h00, 1'b1, 8'h7c);
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== 8'h62)
         $display("FAIL basic_b1 got %b/%h want 1/62", valid_out, data_out);
      else n_pass++;
      drive(1'b0, 8'h00, 1'b0, 8'h00);
      n_checks++;
      if (valid_out !== 1'b0 || data_out !== 8'h62)
         $display("FAIL basic_idle got %b/%h want 0/62", valid_out, data_out);
      else n_pass++;
   endtask

   task automatic test_same_cycle();
      do_reset();
      drive(1'b0, 8'h00, 1'b1, 8'h11); // byte under K=00, then superseded by new message
      drive(1'b1, 8'h00, 1'b1, 8'h63);
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== 8'h00)
         $display("FAIL same_cycle_b0 got %b/%h want 1/00", valid_out, data_out);
      else n_pass++;
      drive(1'b0, 8'h00, 1'b1, 8'h7c);
      n_checks++;
      if (data_out !== 8'h62) $display("FAIL same_cycle_b1 got %h want 62", data_out);
      else n_pass++;
   endtask

   task automatic test_gaps();
      logic [7:0] cs [2];
      logic [7:0] ps [2];
      cs[0] = 8'h63; cs[1] = 8'h7c; ps[0] = 8'h00; ps[1] = 8'h62;
      do_reset();
      drive(1'b1, 8'h00, 1'b0, 8'h00);
      for (int b = 0; b < 2; b++) begin
         drive(1'b0, 8'h00, 1'b1, cs[b]);
         n_checks++;
         if (valid_out !== 1'b1 || data_out !== ps[b])
            $display("FAIL gaps_b%0d got %b/%h want 1/%h", b, valid_out, data_out, ps[b]);
         else n_pass++;
         for (int g = 0; g < 3; g++) begin
            drive(1'b0, 8'h00, 1'b0, 8'hff);
            n_checks++;
            if (valid_out !== 1'b0) $display("FAIL gaps_idle got %b want 0", valid_out);
            else n_pass++;
         end
      end
   endtask

   task automatic round_trip(input int nbytes, input string name);
      logic [7:0] k0, p, c;
      k0 = 8'($urandom);
      m_k = k0; m_idx = 8'h00;
      for (int i = 0; i < nbytes; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            drive(1'b0, 8'($urandom), 1'b0, 8'($urandom));
            n_checks++;
            if (valid_out !== 1'b0) $display("FAIL %s_gap got %b want 0", name, valid_out);
            else n_pass++;
         end
         p = 8'($urandom);
         c = enc(p);
         drive(i == 0, k0, 1'b1, c);
         n_checks++;
         if (valid_out !== 1'b1 || data_out !== p)
            $display("FAIL %s_byte%0d got %b/%h want 1/%h", name, i, valid_out, data_out, p);
         else n_pass++;
      end
   endtask

   task automatic test_round_trip();
      do_reset();
      round_trip(300, "round_trip");
   endtask

   task automatic test_reset_mid();
      do_reset();
      round_trip(5, "pre_reset");
      valid_in = 1'b1; data_in = 8'($urandom);
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (valid_out !== 1'b0 || data_out !== 8'h00)
         $display("FAIL reset_mid got %b/%h want 0/00", valid_out, data_out);
      else n_pass++;
      valid_in = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      round_trip(10, "post_reset");
   endtask

   task automatic test_no_key();
      logic [7:0] c0, c1, k1;
      do_reset();
      c0 = 8'($urandom); c1 = 8'($urandom);
      k1 = {7'h00, 1'b0} ^ c0; // rotl(00) ^ C0 ^ idx 0
      drive(1'b0, 8'hff, 1'b1, c0);
      n_checks++;
      if (data_out !== ref_inv[c0]) $display("FAIL no_key_b0 got %h want %h", data_out, ref_inv[c0]);
      else n_pass++;
      drive(1'b0, 8'hff, 1'b1, c1);
      n_checks++;
      if (data_out !== (ref_inv[c1] ^ k1))
         $display("FAIL no_key_b1 got %h want %h", data_out, ref_inv[c1] ^ k1);
      else n_pass++;
   endtask

`ifdef AES_DECIPHER_ERR_EN
   task automatic test_err();
      do_reset();
      n_checks++;
      if (no_key_err !== 1'b0) $display("FAIL err_reset got %b want 0", no_key_err);
      else n_pass++;
      drive(1'b0, 8'h00, 1'b1, 8'($urandom));
      n_checks++;
      if (no_key_err !== 1'b1) $display("FAIL err_set got %b want 1", no_key_err);
      else n_pass++;
      drive(1'b0, 8'h00, 1'b0, 8'h00);
      n_checks++;
      if (no_key_err !== 1'b1) $display("FAIL err_sticky got %b want 1", no_key_err);
      else n_pass++;
      drive(1'b1, 8'h5a, 1'b0, 8'h00);
      n_checks++;
      if (no_key_err !== 1'b0) $display("FAIL err_clear got %b want 0", no_key_err);
      else n_pass++;
      drive(1'b0, 8'h00, 1'b1, 8'($urandom));
      n_checks++;
      if (no_key_err !== 1'b0) $display("FAIL err_after_key got %b want 0", no_key_err);
      else n_pass++;
   endtask
`endif

   initial begin
      build_tables();
      test_reset();
      test_basic();
      test_same_cycle();
      test_gaps();
      test_round_trip();
      test_reset_mid();
      test_no_key();
`ifdef AES_DECIPHER_ERR_EN
      test_err();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
